// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: default widths, FSM states and
// the {addr, instr} entry carried toward decode.
package fetch_pkg;

  localparam int DEFAULT_ADDR_W     = 16;
  localparam int DEFAULT_INSTR_W    = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0]  addr;
    logic [DEFAULT_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; the head is read straight
// from storage flops and forced to zero while empty.
module fetch_fifo #(
  parameter type T     = logic [15:0],
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Flush takes priority over a coincident push or pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues pc to instruction memory under a credit limit, tags
// responses with their address and flushes everything on a redirect.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int INSTR_W    = DEFAULT_INSTR_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_advance,
  input  logic               redirect,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output fetch_state_t       state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     occupancy;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     discard_base;
  logic [CW-1:0]     discard_next;
  logic [CW:0]       credit_used;
  logic              accept;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              if_pop;
  logic [ADDR_W-1:0] rsp_addr;
  fetch_entry_t      in_entry;
  fetch_entry_t      head_entry;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and offered data holds until transferred.
  assign credit_used    = {1'b0, outstanding} + {1'b0, occupancy};
  assign imem_req_valid = !rst && (state == FETCH) && !redirect &&
                          (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept;

  assign rsp_keep = imem_rsp_valid && (state == FETCH);
  assign if_pop   = if_valid && if_ready;

  fetch_fifo #(
    .T     (logic [ADDR_W-1:0]),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (accept),
    .push_data (pc),
    .pop       (rsp_keep),
    .head      (rsp_addr),
    .count     (outstanding)
  );

  assign in_entry = '{addr: rsp_addr, instr: imem_rsp_data};

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data (in_entry),
    .pop       (if_pop),
    .head      (head_entry),
    .count     (occupancy)
  );

  assign if_valid  = (occupancy != '0);
  assign if_instr  = head_entry.instr;
  assign if_pc     = head_entry.addr;
  assign state_dbg = state;

  // Responses owed to the old stream: in FETCH that is everything
  // outstanding, in FLUSH it is whatever discard still holds.
  assign discard_base = (state == FETCH) ? outstanding : discard;
  assign rsp_drop     = imem_rsp_valid && (discard_base != '0);

  always_comb begin
    discard_next = discard;
    if (redirect) begin
      discard_next = discard_base - CW'(rsp_drop);
    end else if (state == FLUSH && rsp_drop) begin
      discard_next = discard - CW'(1);
    end
    state_next = (discard_next != '0) ? FLUSH : FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      discard <= '0;
    end else begin
      state   <= state_next;
      discard <= discard_next;
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    occupancy <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory and PC-register model plus a queue-level
// reference of in-flight and buffered fetches, checked every cycle.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [15:0]  pc = 16'h0;
  logic         pc_advance;
  logic         redirect = 1'b0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b0;
  logic [15:0]  imem_req_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [15:0]  imem_rsp_data = 16'h0;
  logic         if_valid;
  logic         if_ready = 1'b0;
  logic [15:0]  if_instr;
  logic [15:0]  if_pc;
  fetch_state_t state_dbg;

  instr_fetch #(.ADDR_W(16), .INSTR_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_advance     (pc_advance),
    .redirect       (redirect),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .state_dbg      (state_dbg)
  );

  // reference model state
  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          stale;
  } infl_t;

  infl_t       infl_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_pc = 16'h0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat = 1;

  // per-cycle stimulus chosen by the phases
  bit          d_rst = 1'b1;
  bit          d_redir = 1'b0;
  logic [15:0] d_target = 16'h0;
  bit          d_req_ready = 1'b0;
  bit          d_if_ready = 1'b0;

  // outputs observed in the last cycle
  logic        o_req, o_adv, o_ifv;
  logic [15:0] o_addr, o_ifpc, o_ifinstr;
  logic [31:0] o_state;

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9e37) ^ 16'h5a5a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge,
  // then advance the model to what the next edge must produce.
  task automatic step();
    int    stale_n;
    bit    exp_req, exp_ifv, resp, acc, pop;
    infl_t r;
    int    due;
    @(posedge clk);
    #1;
    cyc++;
    rst            = d_rst;
    redirect       = d_redir;
    imem_req_ready = d_req_ready;
    if_ready       = d_if_ready;
    pc             = m_pc;
    resp = !d_rst && (infl_q.size() > 0) && (infl_q[0].due <= cyc);
    imem_rsp_valid = resp;
    imem_rsp_data  = resp ? mem_word(infl_q[0].addr) : 16'($urandom);
    @(negedge clk);
    stale_n = 0;
    foreach (infl_q[i]) if (infl_q[i].stale) stale_n++;
    exp_req = !d_rst && !d_redir && (stale_n == 0) &&
              (infl_q.size() + exp_q.size() < DEPTH);
    exp_ifv = (exp_q.size() > 0);
    o_req = imem_req_valid; o_adv = pc_advance; o_ifv = if_valid;
    o_addr = imem_req_addr; o_ifpc = if_pc; o_ifinstr = if_instr;
    o_state = 32'(state_dbg);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    chk("pc_advance", 32'(pc_advance), 32'(exp_req && d_req_ready));
    if (exp_req) chk("req_addr", 32'(imem_req_addr), 32'(m_pc));
    chk("if_valid", 32'(if_valid), 32'(exp_ifv));
    if (exp_ifv) begin
      chk("if_pc", 32'(if_pc), 32'(exp_q[0]));
      chk("if_instr", 32'(if_instr), 32'(mem_word(exp_q[0])));
    end
    chk("state", o_state, (stale_n > 0) ? 32'd1 : 32'd0);
    acc = exp_req && d_req_ready;
    pop = exp_ifv && d_if_ready;
    if (d_rst) begin
      infl_q.delete();
      exp_q.delete();
      last_due = 0;
    end else begin
      if (resp) r = infl_q.pop_front();
      if (d_redir) begin
        exp_q.delete();
        foreach (infl_q[i]) infl_q[i].stale = 1'b1;
        m_pc = d_target;
      end else begin
        if (pop) void'(exp_q.pop_front());
        if (resp && !r.stale) exp_q.push_back(r.addr);
        if (acc) begin
          due = cyc + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          infl_q.push_back('{addr: m_pc, due: due, stale: 1'b0});
          m_pc = m_pc + 16'h1;
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    d_rst = 1'b1;
    d_redir = 1'b0;
    repeat (n) step();
    d_rst = 1'b0;
  endtask

  initial begin
    int  n_adv;
    bit  found;
    logic [15:0] p0;

    // A: reset values, then streaming from pc 0 at one instruction per cycle
    m_pc = 16'h0; lat = 1; d_req_ready = 1'b1; d_if_ready = 1'b1;
    do_reset(3);
    chk("A rst if_valid", 32'(o_ifv), 32'd0);
    chk("A rst if_pc", 32'(o_ifpc), 32'd0);
    chk("A rst if_instr", 32'(o_ifinstr), 32'd0);
    chk("A rst req_valid", 32'(o_req), 32'd0);
    chk("A rst pc_advance", 32'(o_adv), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("A req_addr", 32'(o_addr), 32'(i));
      chk("A pc_advance", 32'(o_adv), 32'd1);
      if (i < 2) chk("A early if_valid", 32'(o_ifv), 32'd0);
      else begin
        chk("A stream if_valid", 32'(o_ifv), 32'd1);
        chk("A stream if_pc", 32'(o_ifpc), 32'(i - 2));
      end
    end

    // B: decode stalled, credits run out after four accepts
    m_pc = 16'h0; d_if_ready = 1'b0;
    do_reset(2);
    n_adv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_adv) n_adv++;
    end
    chk("B accept count", 32'(n_adv), 32'd4);
    chk("B req_valid full", 32'(o_req), 32'd0);
    d_if_ready = 1'b1;
    step();
    chk("B head valid", 32'(o_ifv), 32'd1);
    chk("B head pc", 32'(o_ifpc), 32'h0);
    chk("B no req at pop", 32'(o_req), 32'd0);
    step();
    chk("B resume req", 32'(o_adv), 32'd1);
    chk("B resume addr", 32'(o_addr), 32'h4);

    // C: memory not ready for 5 cycles
    d_req_ready = 1'b0;
    p0 = m_pc;
    n_adv = 0;
    repeat (5) begin
      step();
      if (o_adv) n_adv++;
      chk("C addr held", 32'(o_addr), 32'(p0));
    end
    chk("C no advance", 32'(n_adv), 32'd0);
    d_req_ready = 1'b1;
    step();
    chk("C handshake", 32'(o_adv), 32'd1);
    chk("C handshake addr", 32'(o_addr), 32'(p0));

    // D: 3-cycle memory, redirect with two fetches in flight
    m_pc = 16'h0; lat = 3; d_if_ready = 1'b1; d_req_ready = 1'b1;
    do_reset(2);
    step(); step();
    d_req_ready = 1'b0; d_redir = 1'b1; d_target = 16'h0040;
    step();
    chk("D redirect no req", 32'(o_req), 32'd0);
    d_redir = 1'b0; d_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("D drop no req", 32'(o_req), 32'd0);
      chk("D drop if_valid", 32'(o_ifv), 32'd0);
    end
    step();
    chk("D first new req", 32'(o_adv), 32'd1);
    chk("D first new addr", 32'(o_addr), 32'h40);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("D wait if_valid", 32'(o_ifv), 32'd0);
    end
    step();
    chk("D new if_valid", 32'(o_ifv), 32'd1);
    chk("D new if_pc", 32'(o_ifpc), 32'h40);

    // E: redirect together with a response and a decode pop
    m_pc = 16'h0; lat = 1;
    do_reset(2);
    repeat (5) step();
    d_redir = 1'b1; d_target = 16'h0080;
    step();
    chk("E pop pending", 32'(o_ifv), 32'd1);
    d_redir = 1'b0;
    step();
    chk("E flushed", 32'(o_ifv), 32'd0);
    chk("E immediate req", 32'(o_adv), 32'd1);
    chk("E req addr", 32'(o_addr), 32'h80);
    chk("E state", o_state, 32'd0);

    // F: reset with three buffered and one outstanding
    m_pc = 16'h0; d_if_ready = 1'b0;
    do_reset(2);
    repeat (4) step();
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    chk("F if_valid", 32'(o_ifv), 32'd0);
    chk("F if_pc", 32'(o_ifpc), 32'd0);
    chk("F if_instr", 32'(o_ifinstr), 32'd0);
    chk("F restart addr", 32'(o_addr), 32'h4);
    d_if_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_ifv) begin
        found = 1'b1;
        break;
      end
    end
    chk("F delivered", 32'(found), 32'd1);
    chk("F first pc", 32'(o_ifpc), 32'h4);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 3);
      d_req_ready = ($urandom_range(0, 3) != 0);
      d_if_ready  = ($urandom_range(0, 2) != 0);
      d_redir     = ($urandom_range(0, 15) == 0);
      d_target    = 16'($urandom);
      d_rst       = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the program counter register. Each cycle it may issue the current `pc` to instruction memory and pulse `pc_advance` so the PC register loads its next value. It buffers returned instructions, tagged with their fetch address, in a small FIFO toward decode. On a taken branch or jump (`redirect`) it flushes its buffered and in-flight fetches.

## Interface
- `ADDR_W`, 16, PC / instruction memory address width
- `INSTR_W`, 16, instruction width
- `FIFO_DEPTH`, 4, maximum of buffered plus in-flight fetches; power of two, ≥2
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `pc`  in  ADDR_W  current PC register value
- `pc_advance`  out  1  PC register loads PC_Next this edge (= request handshake)
- `redirect`  in  1  taken branch/jump; PC register loads the target this edge independently
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  ADDR_W  request address (= `pc`)
- `imem_rsp_valid`  in  1  in-order response; the memory never stalls responses
- `imem_rsp_data`  in  INSTR_W  fetched instruction
- `if_valid`  out  1  instruction available to decode
- `if_ready`  in  1  decode consumes it
- `if_instr`  out  INSTR_W  instruction at the FIFO head
- `if_pc`  out  ADDR_W  fetch address of `if_instr`

## Operation
- Counters:
  - `outstanding`: accepted requests not yet answered.
  - `occupancy`: FIFO entries.
  - `discard`: responses still to drop.
- FSM, two states:
  - FETCH:
    - `imem_req_valid` = !`redirect` && `outstanding`+`occupancy` < FIFO_DEPTH.
    - Both counts are the registered values.
  - FLUSH:
    - `imem_req_valid`=0.
    - Each response decrements `discard` and is dropped.
    - Go to FETCH on the edge where `discard` reaches 0.
- Request accept, when `imem_req_valid` && `imem_req_ready`:
  - `pc_advance`=1.
  - `pc` is pushed into the in-flight address queue.
  - `outstanding`++.
- Response, when not discarding:
  - Pop the address queue.
  - Push {addr, data} into the instruction FIFO.
  - `outstanding`--.
- Decode handshake (`if_valid` && `if_ready`): pop the instruction FIFO. Push and pop may happen in the same cycle.
- On `redirect`:
  - Flush the instruction FIFO and the address queue.
  - `discard` ← `outstanding` − (response this cycle ? 1 : 0).
  - `outstanding` ← 0.
  - Next state is FLUSH if the new `discard`>0, else FETCH.
  - No request is issued in the redirect cycle.
- Redirect during FLUSH: `discard` keeps counting down the remaining old responses. Nothing new is outstanding.
- Overflow is impossible by the credit rule. The implementation asserts occupancy ≤ FIFO_DEPTH in simulation.
- Reset:
  - State FETCH.
  - All counters 0.
  - Both queues empty.
  - `if_valid`=0, `imem_req_valid`=0, `pc_advance`=0.
  - `if_instr`=0, `if_pc`=0.
  - Reset mid-operation abandons in-flight requests. The memory is reset by the same `rst`.

## Timing
- Request outputs are combinational from registered state plus `redirect`/`pc`.
- `pc_advance` is exactly coincident with the request handshake.
- Minimum request-to-`if_valid` latency: 2 cycles with 1-cycle memory latency.
- A response at edge t makes `if_valid` high in cycle t+1.
- Sustained throughput is 1 instruction/cycle at memory latency 1 with FIFO_DEPTH=4 and `if_ready` held high.
- `if_valid`/`if_instr`/`if_pc` are stable while `if_valid` && !`if_ready`.
- Redirect at edge t:
  - `if_valid`=0 from cycle t+1.
  - The first post-redirect request issues in cycle t+1 if nothing is outstanding, else one cycle after the last discarded response.
- A pop coinciding with `redirect` is ignored; the flush wins.

## Structure
- `fetch_pkg`:
  - ADDR_W/INSTR_W defaults.
  - State enum {FETCH, FLUSH}.
  - Typedef `fetch_entry_t` = {addr, instr}.
- Sub-module `fetch_fifo`: parameterised synchronous FIFO with flush, count output and registered head.
- `fetch_fifo` is instantiated twice:
  - address queue, holding ADDR_W;
  - instruction FIFO, holding `fetch_entry_t`.

## Test plan
- Reset held 3 cycles, then released with `pc`=0x0000, ready=1, 1-cycle memory → requests to 0x0000, 0x0001, …, `pc_advance` every cycle. `if_pc` 0x0000 valid 2 cycles after the first accept, then 1/cycle.
- `if_ready`=0 throughout → exactly 4 accepts, then `imem_req_valid`=0 and `pc_advance`=0. `if_ready`=1 → head is 0x0000, and issue resumes the cycle after the first pop.
- `imem_req_ready` low 5 cycles → no `pc_advance`, `imem_req_addr` held at `pc`. Handshake completes on the first ready cycle.
- 3-cycle memory, 2 outstanding, `redirect` with target 0x0040 → both old responses dropped, `if_valid`=0, no request until the 2nd drop. The next accepted address is 0x0040, and the FIFO then delivers `if_pc`=0x0040.
- `redirect` coincident with a response and a decode pop → response dropped, FIFO empty the next cycle, `discard` = outstanding−1.
- `rst` asserted with 3 entries buffered and 1 outstanding → next cycle all outputs at reset values. After release, fetch restarts from `pc` with no stale instruction delivered.
